// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared widths, types and helpers for the register file read port
package regfile_pkg;

  localparam int NUM_REGS = 16;
  localparam int DATA_W   = 16;
  localparam int ADDR_W   = 4;

  typedef logic [ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0] reg_data_t;

  typedef struct packed {
    reg_data_t data;
    reg_addr_t addr;
  } rd_rsp_t;

  function automatic logic addr_in_range(input reg_addr_t a);
    return ({{(32-ADDR_W){1'b0}}, a} < NUM_REGS);
  endfunction

endpackage

// File: rtl/regfile_read_port_if.sv
// rtl/regfile_read_port_if.sv - request, bitline and response signals of one read port
interface regfile_read_port_if;

  logic                                 req_valid;
  logic                                 req_ready;
  regfile_pkg::reg_addr_t               req_addr;
  logic [regfile_pkg::NUM_REGS-1:0]     read_en;
  regfile_pkg::reg_data_t               bitline;
  logic                                 rsp_valid;
  logic                                 rsp_ready;
  regfile_pkg::reg_data_t               rsp_data;
  regfile_pkg::reg_addr_t               rsp_addr;

  modport master (
    output req_valid, req_addr, bitline, rsp_ready,
    input  req_ready, read_en, rsp_valid, rsp_data, rsp_addr
  );

  modport slave (
    input  req_valid, req_addr, bitline, rsp_ready,
    output req_ready, read_en, rsp_valid, rsp_data, rsp_addr
  );

endinterface

// File: rtl/rsp_fifo2.sv
// rtl/rsp_fifo2.sv - two-entry response FIFO holding sampled read data and its address
module rsp_fifo2
  import regfile_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  rd_rsp_t    push_entry,
  input  logic       pop,
  output rd_rsp_t    head,
  output logic [1:0] count
);

  rd_rsp_t mem [2];
  logic    wr_ptr;
  logic    rd_ptr;
  logic    do_push;
  logic    do_pop;

  assign do_push = push && (count != 2'd2);
  assign do_pop  = pop && (count != 2'd0);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_entry;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/regfile_read_port.sv
// rtl/regfile_read_port.sv - read port: address stage, one-hot read enable, buffered response
// Optional macro REG0_ZERO_EN: register 0 reads as hardwired zero.
module regfile_read_port
  import regfile_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  regfile_read_port_if.slave  bus
);

  logic       a_valid;
  reg_addr_t  a_addr;
  logic       reg_live;
  logic       rd_hit;
  logic       advance;
  logic       pop;
  logic [1:0] buf_count;
  rd_rsp_t    push_entry;
  rd_rsp_t    head;

`ifdef REG0_ZERO_EN
  assign reg_live = (a_addr != '0);
`else
  assign reg_live = 1'b1;
`endif

  // rd_hit gates both the enable and the captured data, so a dead read never samples the bus
  assign rd_hit  = a_valid && addr_in_range(a_addr) && reg_live;
  assign advance = a_valid && (buf_count != 2'd2);
  assign pop     = bus.rsp_valid && bus.rsp_ready;

  assign bus.req_ready = !a_valid || advance;
  assign bus.read_en   = rd_hit ? ({{(NUM_REGS-1){1'b0}}, 1'b1} << a_addr) : '0;
  assign bus.rsp_valid = (buf_count != 2'd0);
  assign bus.rsp_data  = head.data;
  assign bus.rsp_addr  = head.addr;

  always_comb begin
    push_entry      = '0;
    push_entry.addr = a_addr;
    push_entry.data = rd_hit ? bus.bitline : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_valid <= 1'b0;
      a_addr  <= '0;
    end else if (bus.req_valid && bus.req_ready) begin
      a_valid <= 1'b1;
      a_addr  <= bus.req_addr;
    end else if (advance) begin
      a_valid <= 1'b0;
    end
  end

  rsp_fifo2 u_rsp_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (advance),
    .push_entry (push_entry),
    .pop        (pop),
    .head       (head),
    .count      (buf_count)
  );

endmodule

// File: tb/tb_regfile_read_port.sv
// tb/tb_regfile_read_port.sv - self-checking bench for regfile_read_port
module tb_regfile_read_port;
  import regfile_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  regfile_read_port_if bus();

  regfile_read_port dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  reg_data_t regs [NUM_REGS];
  reg_data_t junk;
  reg_data_t bline;

  // register array model: the selected register drives the bus, otherwise noise
  always_comb begin
    bline = junk;
    for (int i = 0; i < NUM_REGS; i++)
      if (bus.read_en[i]) bline = regs[i];
  end
  assign bus.bitline = bline;

  int total = 0;
  int bad = 0;
  int onehot_err = 0;
  int npops = 0;
  rd_rsp_t exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic reg_data_t model_data(input int a);
`ifdef REG0_ZERO_EN
    if (a == 0) return '0;
`endif
    if (a >= NUM_REGS) return '0;
    return regs[a];
  endfunction

  // one cycle of scoreboarded traffic; entered and left at a falling edge
  task automatic cycle_io(input logic rv, input reg_addr_t ra, input logic rr, output logic fired);
    rd_rsp_t e;
    bus.req_valid = rv;
    bus.req_addr  = ra;
    bus.rsp_ready = rr;
    junk = reg_data_t'($urandom);
    #1;
    fired = bus.req_valid && bus.req_ready;
    if (bus.rsp_valid && bus.rsp_ready) begin
      npops++;
      if (exp_q.size() == 0) begin
        chk("unexpected_rsp", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("sb_rsp_data", 32'(bus.rsp_data), 32'(e.data));
        chk("sb_rsp_addr", 32'(bus.rsp_addr), 32'(e.addr));
      end
    end
    if (fired) exp_q.push_back('{data: model_data(int'(ra)), addr: ra});
    if ($countones(bus.read_en) > 1) onehot_err++;
    @(negedge clk);
  endtask

  typedef struct {
    reg_addr_t            addr;
    reg_data_t            pre;
    reg_data_t            during;
    logic [NUM_REGS-1:0]  exp_en;
    reg_data_t            exp_data;
  } vec_t;

  vec_t vecs [4];
  reg_addr_t bp_list [4];

  initial begin
    logic fired;
    int idx;
    int stale;

    vecs[0] = '{addr: 4'd5,  pre: 16'hBEEF, during: 16'hBEEF, exp_en: 16'h0020, exp_data: 16'hBEEF};
    vecs[1] = '{addr: 4'd15, pre: 16'hA5A5, during: 16'hA5A5, exp_en: 16'h8000, exp_data: 16'hA5A5};
    vecs[2] = '{addr: 4'd7,  pre: 16'h0BAD, during: 16'h1234, exp_en: 16'h0080, exp_data: 16'h1234};
`ifdef REG0_ZERO_EN
    vecs[3] = '{addr: 4'd0,  pre: 16'hFFFF, during: 16'hFFFF, exp_en: 16'h0000, exp_data: 16'h0000};
`else
    vecs[3] = '{addr: 4'd0,  pre: 16'hFFFF, during: 16'hFFFF, exp_en: 16'h0001, exp_data: 16'hFFFF};
`endif
    bp_list[0] = 4'd8; bp_list[1] = 4'd9; bp_list[2] = 4'd10; bp_list[3] = 4'd11;

    for (int i = 0; i < NUM_REGS; i++) regs[i] = reg_data_t'($urandom);
    junk = 16'hDEAD;
    rst = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_addr  = '0;
    bus.rsp_ready = 1'b0;
    @(negedge clk);
    #1;
    chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_read_en",   32'(bus.read_en),   32'd0);
    chk("rst_rsp_data",  32'(bus.rsp_data),  32'd0);
    @(negedge clk);
    rst = 1'b0;

    // single reads from the vector table, with hand-checked latency
    foreach (vecs[v]) begin
      regs[vecs[v].addr] = vecs[v].pre;
      bus.req_valid = 1'b1;
      bus.req_addr  = vecs[v].addr;
      bus.rsp_ready = 1'b0;
      #1 chk("single_req_ready", 32'(bus.req_ready), 32'd1);
      @(negedge clk);
      bus.req_valid = 1'b0;
      regs[vecs[v].addr] = vecs[v].during;
      #1;
      chk("single_read_en",  32'(bus.read_en),   32'(vecs[v].exp_en));
      chk("single_early_rv", 32'(bus.rsp_valid), 32'd0);
      @(negedge clk);
      #1;
      chk("single_rsp_valid", 32'(bus.rsp_valid), 32'd1);
      chk("single_rsp_data",  32'(bus.rsp_data),  32'(vecs[v].exp_data));
      chk("single_rsp_addr",  32'(bus.rsp_addr),  32'(vecs[v].addr));
      chk("single_en_idle",   32'(bus.read_en),   32'd0);
      bus.rsp_ready = 1'b1;
      @(negedge clk);
      bus.rsp_ready = 1'b0;
      #1 chk("single_drained", 32'(bus.rsp_valid), 32'd0);
      @(negedge clk);
    end

    // back-to-back stream of addresses 1..4 with the consumer always ready
    for (int k = 0; k < 7; k++) begin
      bus.req_valid = (k < 4);
      bus.req_addr  = reg_addr_t'(k + 1);
      bus.rsp_ready = 1'b1;
      #1;
      if (k < 4) chk("stream_req_ready", 32'(bus.req_ready), 32'd1);
      chk("stream_read_en", 32'(bus.read_en), (k >= 1 && k <= 4) ? (32'd1 << k) : 32'd0);
      chk("stream_rsp_valid", 32'(bus.rsp_valid), (k >= 2 && k <= 5) ? 32'd1 : 32'd0);
      if (k >= 2 && k <= 5) begin
        chk("stream_rsp_addr", 32'(bus.rsp_addr), 32'(k - 1));
        chk("stream_rsp_data", 32'(bus.rsp_data), 32'(regs[k - 1]));
      end
      @(negedge clk);
    end
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b0;

    // backpressure: four requests offered while the consumer stalls
    idx = 0;
    npops = 0;
    for (int c = 0; c < 6; c++) begin
      cycle_io(1'b1, bp_list[idx < 4 ? idx : 3], 1'b0, fired);
      if (fired) idx++;
    end
    #1;
    chk("bp_accepted",  32'(idx), 32'd3);
    chk("bp_req_ready", 32'(bus.req_ready), 32'd0);
    chk("bp_read_en",   32'(bus.read_en), 32'h0400);
    chk("bp_head_addr", 32'(bus.rsp_addr), 32'd8);
    @(negedge clk);
    for (int c = 0; c < 20 && (idx < 4 || exp_q.size() != 0); c++) begin
      cycle_io(idx < 4, idx < 4 ? bp_list[idx] : 4'd0, 1'b1, fired);
      if (fired) idx++;
    end
    chk("bp_all_drained", 32'(exp_q.size()), 32'd0);
    chk("bp_pop_count",   32'(npops), 32'd4);

    // randomized traffic against the scoreboard
    for (int c = 0; c < 1500; c++)
      cycle_io(($urandom % 4) != 0, reg_addr_t'($urandom), ($urandom % 3) != 0, fired);
    for (int c = 0; c < 50 && (exp_q.size() != 0 || bus.rsp_valid); c++)
      cycle_io(1'b0, '0, 1'b1, fired);
    chk("rand_drained",  32'(exp_q.size()), 32'd0);
    chk("rand_onehot",   32'(onehot_err), 32'd0);

    // reset while two responses are buffered and a third read is in flight
    for (int c = 0; c < 3; c++) cycle_io(1'b1, reg_addr_t'(c + 2), 1'b0, fired);
    bus.req_valid = 1'b0;
    #1;
    chk("mid_pre_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    chk("mid_pre_req_ready", 32'(bus.req_ready), 32'd0);
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("mid_rst_read_en",   32'(bus.read_en),   32'd0);
    chk("mid_rst_req_ready", 32'(bus.req_ready), 32'd1);
    chk("mid_rst_rsp_addr",  32'(bus.rsp_addr),  32'd0);
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    stale = 0;
    for (int c = 0; c < 5; c++) begin
      bus.rsp_ready = 1'b1;
      #1;
      if (bus.rsp_valid) stale++;
      @(negedge clk);
    end
    chk("mid_no_stale", 32'(stale), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end

endmodule
